// File: rtl/xc_rf_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | xc_rf_pkg : shared constants and pair-addressing helpers        |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
package xc_rf_pkg;

    localparam int REG_AW = 5;
    localparam int NREGS  = 32;

    // A wide operation covers the even/odd pair, so only addr[4:1] is compared.
    function automatic logic match(
        input logic [REG_AW-1:0] addr,
        input logic [REG_AW-1:0] dst,
        input logic              wide
    );
        return wide ? (addr[REG_AW-1:1] == dst[REG_AW-1:1]) : (addr == dst);
    endfunction

    function automatic logic sel_hi(input logic addr_lsb, input logic wide);
        return wide & addr_lsb;
    endfunction

    function automatic logic [NREGS-1:0] pair_mask(
        input logic [REG_AW-1:0] addr,
        input logic              wide
    );
        logic [NREGS-1:0] m;
        m = '0;
        if (wide) begin
            m[{addr[REG_AW-1:1], 1'b0}] = 1'b1;
            m[{addr[REG_AW-1:1], 1'b1}] = 1'b1;
        end else begin
            m[addr] = 1'b1;
        end
        m[0] = 1'b0;
        return m;
    endfunction

endpackage
`default_nettype wire

// File: rtl/xc_rf_fwd_port.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | xc_rf_fwd_port : one read port, forwarding priority mux + stall |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
module xc_rf_fwd_port
    import xc_rf_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int NFWD = 2
) (
    input  logic [REG_AW-1:0]      addr,
    input  logic [NFWD-1:0]        fwd_wen,
    input  logic [NFWD-1:0]        fwd_wide,
    input  logic [REG_AW*NFWD-1:0] fwd_addr,
    input  logic [XLEN*NFWD-1:0]   fwd_wdata,
    input  logic [XLEN*NFWD-1:0]   fwd_wdata_hi,
    input  logic                   rd_wen,
    input  logic                   rd_wide,
    input  logic [REG_AW-1:0]      rd_addr,
    input  logic [XLEN-1:0]        rd_wdata,
    input  logic [XLEN-1:0]        rd_wdata_hi,
    input  logic [NREGS-1:0]       busy,
    input  logic [XLEN-1:0]        store_data,
    output logic [XLEN-1:0]        rdata,
    output logic                   stall
);

    logic w_hit;

    // Walk oldest to youngest so the youngest matching stage overrides.
    always_comb begin
        w_hit = 1'b0;
        rdata = store_data;
        if (addr == '0) begin
            rdata = '0;
            w_hit = 1'b1;
        end else begin
            if (rd_wen && match(addr, rd_addr, rd_wide)) begin
                rdata = sel_hi(addr[0], rd_wide) ? rd_wdata_hi : rd_wdata;
                w_hit = 1'b1;
            end
            for (int k = NFWD - 1; k >= 0; k--) begin
                if (fwd_wen[k] && match(addr, fwd_addr[REG_AW*k +: REG_AW], fwd_wide[k])) begin
                    rdata = sel_hi(addr[0], fwd_wide[k]) ? fwd_wdata_hi[XLEN*k +: XLEN]
                                                         : fwd_wdata[XLEN*k +: XLEN];
                    w_hit = 1'b1;
                end
            end
        end
    end

    assign stall = busy[addr] & ~w_hit;

endmodule
`default_nettype wire

// File: rtl/xc_rf_fwd_sb.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | xc_rf_fwd_sb : forwarding GPR file with pair writes + scoreboard |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
module xc_rf_fwd_sb
    import xc_rf_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int NREAD = 3,
    parameter int NFWD  = 2
) (
    input  logic                    clock,
    input  logic                    resetn,
    input  logic [REG_AW*NREAD-1:0] rs_addr,
    output logic [XLEN*NREAD-1:0]   rs_rdata,
    output logic [NREAD-1:0]        rs_stall,
    input  logic [NFWD-1:0]         fwd_wen,
    input  logic [NFWD-1:0]         fwd_wide,
    input  logic [REG_AW*NFWD-1:0]  fwd_addr,
    input  logic [XLEN*NFWD-1:0]    fwd_wdata,
    input  logic [XLEN*NFWD-1:0]    fwd_wdata_hi,
    input  logic                    rd_wen,
    input  logic                    rd_wide,
    input  logic [REG_AW-1:0]       rd_addr,
    input  logic [XLEN-1:0]         rd_wdata,
    input  logic [XLEN-1:0]         rd_wdata_hi,
    input  logic                    issue_en,
    input  logic                    issue_wide,
    input  logic [REG_AW-1:0]       issue_addr,
    input  logic                    flush,
    output logic [5:0]              busy_count
);

    logic [XLEN-1:0]  r_regs [NREGS];
    logic [NREGS-1:0] r_busy;
    logic [5:0]       r_busy_count;
    logic [NREGS-1:0] w_wmask;
    logic [NREGS-1:0] w_busy_next;
    logic [5:0]       w_busy_cnt;

    // pair_mask never selects x0, so x0 keeps its reset value forever.
    assign w_wmask = rd_wen ? pair_mask(rd_addr, rd_wide) : '0;

    always_ff @(posedge clock) begin
        for (int j = 0; j < NREGS; j++) begin
            if (!resetn) begin
                r_regs[j] <= '0;
            end else if (w_wmask[j]) begin
                r_regs[j] <= (rd_wide && (j % 2 == 1)) ? rd_wdata_hi : rd_wdata;
            end
        end
    end

    // Clear first, then set, so a same-cycle issue wins over writeback and flush.
    always_comb begin
        w_busy_next = flush ? '0 : (r_busy & ~w_wmask);
        if (issue_en) begin
            w_busy_next = w_busy_next | pair_mask(issue_addr, issue_wide);
        end
        w_busy_next[0] = 1'b0;
        w_busy_cnt = '0;
        for (int i = 0; i < NREGS; i++) begin
            w_busy_cnt = w_busy_cnt + {5'b0, w_busy_next[i]};
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_busy       <= '0;
            r_busy_count <= '0;
        end else begin
            r_busy       <= w_busy_next;
            r_busy_count <= w_busy_cnt;
        end
    end

    assign busy_count = r_busy_count;

    for (genvar i = 0; i < NREAD; i++) begin : g_port
        logic [REG_AW-1:0] w_addr;
        assign w_addr = rs_addr[REG_AW*i +: REG_AW];

        xc_rf_fwd_port #(
            .XLEN (XLEN),
            .NFWD (NFWD)
        ) u_port (
            .addr         (w_addr),
            .fwd_wen      (fwd_wen),
            .fwd_wide     (fwd_wide),
            .fwd_addr     (fwd_addr),
            .fwd_wdata    (fwd_wdata),
            .fwd_wdata_hi (fwd_wdata_hi),
            .rd_wen       (rd_wen),
            .rd_wide      (rd_wide),
            .rd_addr      (rd_addr),
            .rd_wdata     (rd_wdata),
            .rd_wdata_hi  (rd_wdata_hi),
            .busy         (r_busy),
            .store_data   (r_regs[w_addr]),
            .rdata        (rs_rdata[XLEN*i +: XLEN]),
            .stall        (rs_stall[i])
        );
    end

endmodule
`default_nettype wire

// File: tb/tb_xc_rf_fwd_sb.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | tb_xc_rf_fwd_sb : scoreboard-driven bench for xc_rf_fwd_sb      |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
module tb_xc_rf_fwd_sb;

    localparam int XLEN  = 32;
    localparam int NREAD = 3;
    localparam int NFWD  = 2;

    logic                  clock;
    logic                  resetn;
    logic [5*NREAD-1:0]    rs_addr;
    logic [XLEN*NREAD-1:0] rs_rdata;
    logic [NREAD-1:0]      rs_stall;
    logic [NFWD-1:0]       fwd_wen;
    logic [NFWD-1:0]       fwd_wide;
    logic [5*NFWD-1:0]     fwd_addr;
    logic [XLEN*NFWD-1:0]  fwd_wdata;
    logic [XLEN*NFWD-1:0]  fwd_wdata_hi;
    logic                  rd_wen;
    logic                  rd_wide;
    logic [4:0]            rd_addr;
    logic [XLEN-1:0]       rd_wdata;
    logic [XLEN-1:0]       rd_wdata_hi;
    logic                  issue_en;
    logic                  issue_wide;
    logic [4:0]            issue_addr;
    logic                  flush;
    logic [5:0]            busy_count;

    xc_rf_fwd_sb #(.XLEN(XLEN), .NREAD(NREAD), .NFWD(NFWD)) dut (
        .clock        (clock),
        .resetn       (resetn),
        .rs_addr      (rs_addr),
        .rs_rdata     (rs_rdata),
        .rs_stall     (rs_stall),
        .fwd_wen      (fwd_wen),
        .fwd_wide     (fwd_wide),
        .fwd_addr     (fwd_addr),
        .fwd_wdata    (fwd_wdata),
        .fwd_wdata_hi (fwd_wdata_hi),
        .rd_wen       (rd_wen),
        .rd_wide      (rd_wide),
        .rd_addr      (rd_addr),
        .rd_wdata     (rd_wdata),
        .rd_wdata_hi  (rd_wdata_hi),
        .issue_en     (issue_en),
        .issue_wide   (issue_wide),
        .issue_addr   (issue_addr),
        .flush        (flush),
        .busy_count   (busy_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // kind: 0 = read data, 1 = stall bit, 2 = busy_count
    typedef struct {
        string       name;
        int          kind;
        int          port;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic logic [31:0] observe(int kind, int port);
        case (kind)
            0:       return rs_rdata[XLEN*port +: XLEN];
            1:       return {31'b0, rs_stall[port]};
            default: return {26'b0, busy_count};
        endcase
    endfunction

    task automatic step();
        @(negedge clock);
    endtask

    task automatic idle();
        fwd_wen = '0; fwd_wide = '0; fwd_addr = '0; fwd_wdata = '0; fwd_wdata_hi = '0;
        rd_wen = 1'b0; rd_wide = 1'b0; rd_addr = '0; rd_wdata = '0; rd_wdata_hi = '0;
        issue_en = 1'b0; issue_wide = 1'b0; issue_addr = '0; flush = 1'b0;
        rs_addr = '0;
    endtask

    task automatic push_read(string name, int port, logic [4:0] a, logic [31:0] d, logic st);
        exp_t e;
        rs_addr[5*port +: 5] = a;
        e.name = {name, "_data"}; e.kind = 0; e.port = port; e.val = d;
        sb.push_back(e);
        e.name = {name, "_stall"}; e.kind = 1; e.val = {31'b0, st};
        sb.push_back(e);
    endtask

    task automatic push_count(string name, logic [5:0] c);
        exp_t e;
        e.name = name; e.kind = 2; e.port = 0; e.val = {26'b0, c};
        sb.push_back(e);
    endtask

    task automatic test_reset();
        exp_t e;
        logic [31:0] obs;
        idle();
        resetn = 1'b0;
        step(); step();
        resetn = 1'b1;
        for (int a = 1; a < 32; a += 3) begin
            for (int p = 0; p < NREAD; p++) begin
                if (a + p < 32)
                    push_read($sformatf("reset_x%0d", a + p), p, 5'(a + p), 32'h0, 1'b0);
            end
            push_count("reset_count", 6'd0);
            #1;
            while (sb.size() > 0) begin
                e = sb.pop_front(); obs = observe(e.kind, e.port); n_cmp++;
                if (obs !== e.val) begin
                    n_bad++;
                    $display("FAIL %s: got %h want %h", e.name, obs, e.val);
                end
            end
        end
    endtask

    task automatic test_wide_write();
        exp_t e;
        logic [31:0] obs;
        idle();
        rd_wen = 1'b1; rd_wide = 1'b1; rd_addr = 5'd5;
        rd_wdata = 32'h1111_1111; rd_wdata_hi = 32'h2222_2222;
        step();
        idle();
        rd_wen = 1'b1; rd_wide = 1'b1; rd_addr = 5'd0;
        rd_wdata = 32'h0000_0044; rd_wdata_hi = 32'h0000_0033;
        push_read("wide_x4", 0, 5'd4, 32'h1111_1111, 1'b0);
        push_read("wide_x5", 1, 5'd5, 32'h2222_2222, 1'b0);
        push_read("wide_x0_fwd", 2, 5'd0, 32'h0, 1'b0);
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front(); obs = observe(e.kind, e.port); n_cmp++;
            if (obs !== e.val) begin
                n_bad++;
                $display("FAIL %s: got %h want %h", e.name, obs, e.val);
            end
        end
        step();
        idle();
        push_read("pair0_x0", 0, 5'd0, 32'h0, 1'b0);
        push_read("pair0_x1", 1, 5'd1, 32'h33, 1'b0);
        push_read("pair0_x2", 2, 5'd2, 32'h0, 1'b0);
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front(); obs = observe(e.kind, e.port); n_cmp++;
            if (obs !== e.val) begin
                n_bad++;
                $display("FAIL %s: got %h want %h", e.name, obs, e.val);
            end
        end
    endtask

    task automatic test_fwd_priority();
        exp_t e;
        logic [31:0] obs;
        logic [31:0] want [4];
        idle();
        rd_wen = 1'b1; rd_addr = 5'd7; rd_wdata = 32'h77;
        step();
        idle();
        fwd_wen = 2'b11;
        fwd_addr = {5'd7, 5'd7};
        fwd_wdata = {32'hBB, 32'hAA};
        rd_wen = 1'b1; rd_addr = 5'd7; rd_wdata = 32'hCC;
        want[0] = 32'hAA; want[1] = 32'hBB; want[2] = 32'hCC; want[3] = 32'h77;
        for (int s = 0; s < 4; s++) begin
            if (s == 1) fwd_wen[0] = 1'b0;
            if (s == 2) fwd_wen[1] = 1'b0;
            if (s == 3) rd_wen = 1'b0;
            push_read($sformatf("prio%0d_p0", s), 0, 5'd7, want[s], 1'b0);
            push_read($sformatf("prio%0d_p2", s), 2, 5'd7, want[s], 1'b0);
            push_read($sformatf("prio%0d_x6", s), 1, 5'd6, 32'h0, 1'b0);
            #1;
            while (sb.size() > 0) begin
                e = sb.pop_front(); obs = observe(e.kind, e.port); n_cmp++;
                if (obs !== e.val) begin
                    n_bad++;
                    $display("FAIL %s: got %h want %h", e.name, obs, e.val);
                end
            end
        end
        // wide forward from stage 1 beats narrow rd; odd read takes hi half
        fwd_wen = 2'b10; fwd_wide = 2'b10; fwd_addr = {5'd6, 5'd0};
        fwd_wdata = {32'hE6, 32'h0}; fwd_wdata_hi = {32'hE7, 32'h0};
        rd_wen = 1'b1; rd_addr = 5'd7; rd_wdata = 32'hCC;
        push_read("widefwd_x7", 0, 5'd7, 32'hE7, 1'b0);
        push_read("widefwd_x6", 1, 5'd6, 32'hE6, 1'b0);
        push_read("widefwd_x8", 2, 5'd8, 32'h0, 1'b0);
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front(); obs = observe(e.kind, e.port); n_cmp++;
            if (obs !== e.val) begin
                n_bad++;
                $display("FAIL %s: got %h want %h", e.name, obs, e.val);
            end
        end
        idle();
        step();
    endtask

    task automatic test_scoreboard();
        exp_t e;
        logic [31:0] obs;
        idle();
        issue_en = 1'b1; issue_wide = 1'b1; issue_addr = 5'd10;
        step();
        idle();
        push_count("sb_issue_count", 6'd2);
        push_read("sb_x10", 0, 5'd10, 32'h0, 1'b1);
        push_read("sb_x11", 1, 5'd11, 32'h0, 1'b1);
        push_read("sb_x12", 2, 5'd12, 32'h0, 1'b0);
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front(); obs = observe(e.kind, e.port); n_cmp++;
            if (obs !== e.val) begin
                n_bad++;
                $display("FAIL %s: got %h want %h", e.name, obs, e.val);
            end
        end
        fwd_wen = 2'b01; fwd_wide = 2'b01; fwd_addr = {5'd0, 5'd10};
        fwd_wdata = {32'h0, 32'h4}; fwd_wdata_hi = {32'h0, 32'h5};
        push_read("sb_fwd_x11", 1, 5'd11, 32'h5, 1'b0);
        push_read("sb_fwd_x10", 0, 5'd10, 32'h4, 1'b0);
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front(); obs = observe(e.kind, e.port); n_cmp++;
            if (obs !== e.val) begin
                n_bad++;
                $display("FAIL %s: got %h want %h", e.name, obs, e.val);
            end
        end
        idle();
        rd_wen = 1'b1; rd_wide = 1'b1; rd_addr = 5'd11;
        rd_wdata = 32'hA0; rd_wdata_hi = 32'hA1;
        step();
        idle();
        push_count("sb_clear_count", 6'd0);
        push_read("sb_wb_x11", 1, 5'd11, 32'hA1, 1'b0);
        push_read("sb_wb_x10", 0, 5'd10, 32'hA0, 1'b0);
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front(); obs = observe(e.kind, e.port); n_cmp++;
            if (obs !== e.val) begin
                n_bad++;
                $display("FAIL %s: got %h want %h", e.name, obs, e.val);
            end
        end
    endtask

    task automatic test_simultaneous();
        exp_t e;
        logic [31:0] obs;
        idle();
        issue_en = 1'b1; issue_addr = 5'd3;
        step();
        issue_en = 1'b1; issue_addr = 5'd3;
        rd_wen = 1'b1; rd_addr = 5'd3; rd_wdata = 32'h3333;
        step();
        idle();
        push_count("simul_count", 6'd1);
        push_read("simul_x3", 0, 5'd3, 32'h3333, 1'b1);
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front(); obs = observe(e.kind, e.port); n_cmp++;
            if (obs !== e.val) begin
                n_bad++;
                $display("FAIL %s: got %h want %h", e.name, obs, e.val);
            end
        end
        issue_en = 1'b1; issue_addr = 5'd3;
        step();
        issue_addr = 5'd20;
        step();
        idle();
        push_count("reissue_count", 6'd2);
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front(); obs = observe(e.kind, e.port); n_cmp++;
            if (obs !== e.val) begin
                n_bad++;
                $display("FAIL %s: got %h want %h", e.name, obs, e.val);
            end
        end
        flush = 1'b1; issue_en = 1'b1; issue_addr = 5'd9;
        step();
        idle();
        push_count("flush_count", 6'd1);
        push_read("flush_x9", 0, 5'd9, 32'h0, 1'b1);
        push_read("flush_x3", 1, 5'd3, 32'h3333, 1'b0);
        push_read("flush_x20", 2, 5'd20, 32'h0, 1'b0);
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front(); obs = observe(e.kind, e.port); n_cmp++;
            if (obs !== e.val) begin
                n_bad++;
                $display("FAIL %s: got %h want %h", e.name, obs, e.val);
            end
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        logic [31:0] obs;
        idle();
        for (int r = 13; r < 16; r++) begin
            rd_wen = 1'b1; rd_addr = 5'(r); rd_wdata = 32'hD000_0000 + 32'(r);
            step();
        end
        idle();
        for (int p = 0; p < NREAD; p++)
            push_read($sformatf("b2b_x%0d", 13 + p), p, 5'(13 + p), 32'hD000_0000 + 32'(13 + p), 1'b0);
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front(); obs = observe(e.kind, e.port); n_cmp++;
            if (obs !== e.val) begin
                n_bad++;
                $display("FAIL %s: got %h want %h", e.name, obs, e.val);
            end
        end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        logic [31:0] obs;
        idle();
        resetn = 1'b0;
        rd_wen = 1'b1; rd_addr = 5'd8; rd_wdata = 32'hFF;
        issue_en = 1'b1; issue_addr = 5'd8;
        step();
        resetn = 1'b1;
        idle();
        push_count("rstmid_count", 6'd0);
        push_read("rstmid_x8", 0, 5'd8, 32'h0, 1'b0);
        push_read("rstmid_x4", 1, 5'd4, 32'h0, 1'b0);
        push_read("rstmid_x9", 2, 5'd9, 32'h0, 1'b0);
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front(); obs = observe(e.kind, e.port); n_cmp++;
            if (obs !== e.val) begin
                n_bad++;
                $display("FAIL %s: got %h want %h", e.name, obs, e.val);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "timeout");
    end

    initial begin
        resetn = 1'b0;
        idle();
        test_reset();
        test_wide_write();
        test_fwd_priority();
        test_scoreboard();
        test_simultaneous();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
